// File: rtl/vote_session_ctrl_pkg.sv
// Shared types and defaults for the voting-session controller: state encoding,
// default sizing and a one-hot check used when decoding candidate buttons.
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        ARMED  = 2'd2,
        CLOSED = 2'd3
    } state_t;

    localparam int N_CAND_DEF        = 4;
    localparam int CNT_W_DEF         = 8;
    localparam int TIMEOUT_TICKS_DEF = 60;
    localparam int MAX_CAND          = 8;

    // True when exactly one bit is set; narrower vectors are zero-extended by the caller.
    function automatic logic is_one_hot(input logic [MAX_CAND-1:0] v);
        return (v != '0) && ((v & (v - MAX_CAND'(1))) == '0);
    endfunction

endpackage

// File: rtl/vote_session_ctrl_if.sv
// Officer/voter controls and session status of the voting-session controller.
// The audit counters exist only when VOTE_AUDIT_EN is defined.
interface vote_session_ctrl_if #(
    parameter int N_CAND = 4,
    parameter int CNT_W  = 8
);
    logic                    tick;
    logic                    open_req;
    logic                    close_req;
    logic                    next_voter;
    logic [N_CAND-1:0]       vote_req;
    logic                    led_enable;
    logic                    ballot_armed;
    logic                    vote_ack;
    logic                    vote_err;
    logic                    timeout;
    logic [N_CAND*CNT_W-1:0] tally;
    logic                    result_valid;
    logic [2:0]              winner;
    logic                    tie;
`ifdef VOTE_AUDIT_EN
    logic [CNT_W+2:0]        total_votes;
    logic [CNT_W-1:0]        reject_cnt;
`endif

    modport master (
        output tick, open_req, close_req, next_voter, vote_req,
        input  led_enable, ballot_armed, vote_ack, vote_err, timeout,
               tally, result_valid, winner, tie
`ifdef VOTE_AUDIT_EN
        , input total_votes, reject_cnt
`endif
    );

    modport slave (
        input  tick, open_req, close_req, next_voter, vote_req,
        output led_enable, ballot_armed, vote_ack, vote_err, timeout,
               tally, result_valid, winner, tie
`ifdef VOTE_AUDIT_EN
        , output total_votes, reject_cnt
`endif
    );

endinterface

// File: rtl/vote_session_ctrl_max_scan.sv
// Sequential argmax over the packed tallies: one candidate per clock after a
// start pulse; lowest index wins ties, done holds until reset.
module max_scan #(
    parameter int N_CAND = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [N_CAND*CNT_W-1:0] tally,
    output logic                    done,
    output logic [2:0]              winner,
    output logic                    tie
);

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [2:0]       winner_q, winner_d;
    logic             tie_q, tie_d;
    logic [CNT_W-1:0] cur;

    assign cur = tally[idx_q*CNT_W +: CNT_W];

    always_comb begin
        busy_d   = busy_q;
        done_d   = done_q;
        idx_d    = idx_q;
        max_d    = max_q;
        winner_d = winner_q;
        tie_d    = tie_q;
        if (start && !busy_q && !done_q) begin
            busy_d = 1'b1;
            idx_d  = 3'd0;
        end else if (busy_q) begin
            // Candidate 0 seeds the running max so an all-zero field still reports a tie.
            if (idx_q == 3'd0 || cur > max_q) begin
                max_d    = cur;
                winner_d = idx_q;
                tie_d    = 1'b0;
            end else if (cur == max_q) begin
                tie_d = 1'b1;
            end
            if (idx_q == 3'(N_CAND-1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= 3'd0;
            max_q    <= '0;
            winner_q <= 3'd0;
            tie_q    <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            idx_q    <= idx_d;
            max_q    <= max_d;
            winner_q <= winner_d;
            tie_q    <= tie_d;
        end
    end

    assign done   = done_q;
    assign winner = winner_q;
    assign tie    = tie_q;

endmodule

// File: rtl/vote_session_ctrl.sv
// Voting-session sequencer: session FSM, saturating per-candidate tallies and
// winner scan after close. Define VOTE_AUDIT_EN to add total_votes/reject_cnt.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int N_CAND        = N_CAND_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    vote_session_ctrl_if.slave   bus
);

    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

    state_t                  state_q, state_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic                    led_enable_q, led_enable_d;
    logic                    ballot_armed_q, ballot_armed_d;
    logic                    vote_ack_q, vote_ack_d;
    logic                    vote_err_q, vote_err_d;
    logic                    timeout_q, timeout_d;
    logic                    start_q, start_d;
    logic                    count_en;
    logic                    valid_vote;
    logic                    any_vote;
    logic [N_CAND*CNT_W-1:0] tally_w;

    assign valid_vote = is_one_hot(MAX_CAND'(bus.vote_req));
    assign any_vote   = |bus.vote_req;

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        vote_ack_d = 1'b0;
        vote_err_d = 1'b0;
        timeout_d  = 1'b0;
        count_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.open_req) state_d = OPEN;
            end
            OPEN: begin
                if (bus.close_req) begin
                    state_d = CLOSED;
                end else if (bus.next_voter) begin
                    state_d  = ARMED;
                    to_cnt_d = '0;
                end
            end
            ARMED: begin
                // close beats a valid vote, which beats expiry; a vote with close is dropped
                if (bus.close_req) begin
                    state_d = CLOSED;
                end else if (valid_vote) begin
                    count_en   = 1'b1;
                    vote_ack_d = 1'b1;
                    state_d    = OPEN;
                end else begin
                    vote_err_d = any_vote;
                    if (bus.tick) begin
                        if (to_cnt_q == TO_W'(TIMEOUT_TICKS - 1)) begin
                            timeout_d = 1'b1;
                            to_cnt_d  = '0;
                            state_d   = OPEN;
                        end else begin
                            to_cnt_d = to_cnt_q + TO_W'(1);
                        end
                    end
                end
            end
            CLOSED: ;
            default: state_d = IDLE;
        endcase
        led_enable_d   = (state_d == OPEN) || (state_d == ARMED);
        ballot_armed_d = (state_d == ARMED);
        start_d        = (state_d == CLOSED) && (state_q != CLOSED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            to_cnt_q       <= '0;
            led_enable_q   <= 1'b0;
            ballot_armed_q <= 1'b0;
            vote_ack_q     <= 1'b0;
            vote_err_q     <= 1'b0;
            timeout_q      <= 1'b0;
            start_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            to_cnt_q       <= to_cnt_d;
            led_enable_q   <= led_enable_d;
            ballot_armed_q <= ballot_armed_d;
            vote_ack_q     <= vote_ack_d;
            vote_err_q     <= vote_err_d;
            timeout_q      <= timeout_d;
            start_q        <= start_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CAND; gi++) begin : g_tally
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Saturated counters hold; the vote is still acknowledged.
            always_comb begin
                cnt_d = cnt_q;
                if (count_en && bus.vote_req[gi] && (cnt_q != '1))
                    cnt_d = cnt_q + CNT_W'(1);
            end

            always_ff @(posedge clk) begin
                if (reset) cnt_q <= '0;
                else       cnt_q <= cnt_d;
            end

            assign tally_w[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate

    max_scan #(
        .N_CAND (N_CAND),
        .CNT_W  (CNT_W)
    ) u_max_scan (
        .clk    (clk),
        .reset  (reset),
        .start  (start_q),
        .tally  (tally_w),
        .done   (bus.result_valid),
        .winner (bus.winner),
        .tie    (bus.tie)
    );

    assign bus.led_enable   = led_enable_q;
    assign bus.ballot_armed = ballot_armed_q;
    assign bus.vote_ack     = vote_ack_q;
    assign bus.vote_err     = vote_err_q;
    assign bus.timeout      = timeout_q;
    assign bus.tally        = tally_w;

`ifdef VOTE_AUDIT_EN
    logic [CNT_W+2:0] total_q, total_d;
    logic [CNT_W-1:0] reject_q, reject_d;
    logic [CNT_W:0]   reject_sum;

    always_comb begin
        total_d    = total_q + (CNT_W+3)'(vote_ack_d);
        reject_sum = {1'b0, reject_q} + (CNT_W+1)'(vote_err_d) + (CNT_W+1)'(timeout_d);
        reject_d   = reject_sum[CNT_W] ? '1 : reject_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q  <= '0;
            reject_q <= '0;
        end else begin
            total_q  <= total_d;
            reject_q <= reject_d;
        end
    end

    assign bus.total_votes = total_q;
    assign bus.reject_cnt  = reject_q;
`endif

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed bench for vote_session_ctrl: a default instance plus a CNT_W=2
// instance for tally saturation; outputs sampled 1 ns after each rising edge.
module tb_vote_session_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  vote_session_ctrl_if #(.N_CAND(4), .CNT_W(8)) bus_a ();
  vote_session_ctrl_if #(.N_CAND(4), .CNT_W(2)) bus_b ();

  vote_session_ctrl #(.N_CAND(4), .CNT_W(8), .TIMEOUT_TICKS(60)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  vote_session_ctrl #(.N_CAND(4), .CNT_W(2), .TIMEOUT_TICKS(60)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_open_a();
    bus_a.open_req = 1'b1; step(); bus_a.open_req = 1'b0;
  endtask

  task automatic pulse_next_a();
    bus_a.next_voter = 1'b1; step(); bus_a.next_voter = 1'b0;
  endtask

  task automatic pulse_vote_a(input logic [3:0] v);
    bus_a.vote_req = v; step(); bus_a.vote_req = 4'b0;
  endtask

  task automatic cast_a(input int cand, input int n);
    for (int k = 0; k < n; k++) begin
      pulse_next_a();
      pulse_vote_a(4'(1 << cand));
    end
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (bus_a.led_enable !== 1'b0 || bus_a.ballot_armed !== 1'b0 || bus_a.vote_ack !== 1'b0 ||
        bus_a.vote_err !== 1'b0 || bus_a.timeout !== 1'b0) begin
      $display("FAIL reset_ctrl: got led=%b arm=%b ack=%b err=%b to=%b, want all 0",
               bus_a.led_enable, bus_a.ballot_armed, bus_a.vote_ack, bus_a.vote_err, bus_a.timeout);
    end else pass_cnt++;
    total_cnt++;
    if (bus_a.tally !== 32'h0 || bus_a.result_valid !== 1'b0 || bus_a.winner !== 3'd0 || bus_a.tie !== 1'b0) begin
      $display("FAIL reset_result: got tally=%h rv=%b win=%0d tie=%b, want 0", bus_a.tally,
               bus_a.result_valid, bus_a.winner, bus_a.tie);
    end else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_open();
    // Inputs other than open_req are ignored in IDLE.
    pulse_next_a();
    total_cnt++;
    if (bus_a.led_enable !== 1'b0 || bus_a.ballot_armed !== 1'b0) begin
      $display("FAIL idle_ignore: got led=%b arm=%b, want 0 0", bus_a.led_enable, bus_a.ballot_armed);
    end else pass_cnt++;
    pulse_open_a();
    total_cnt++;
    if (bus_a.led_enable !== 1'b1 || bus_a.ballot_armed !== 1'b0) begin
      $display("FAIL open_state: got led=%b arm=%b, want 1 0", bus_a.led_enable, bus_a.ballot_armed);
    end else pass_cnt++;
    pulse_vote_a(4'b0010);
    total_cnt++;
    if (bus_a.vote_ack !== 1'b0 || bus_a.vote_err !== 1'b0 || bus_a.tally !== 32'h0) begin
      $display("FAIL open_vote_ignored: got ack=%b err=%b tally=%h, want 0 0 0",
               bus_a.vote_ack, bus_a.vote_err, bus_a.tally);
    end else pass_cnt++;
    $display("test_open done");
  endtask

  task automatic test_vote();
    pulse_next_a();
    total_cnt++;
    if (bus_a.ballot_armed !== 1'b1 || bus_a.led_enable !== 1'b1) begin
      $display("FAIL armed_state: got arm=%b led=%b, want 1 1", bus_a.ballot_armed, bus_a.led_enable);
    end else pass_cnt++;
    pulse_vote_a(4'b0100);
    total_cnt++;
    if (bus_a.vote_ack !== 1'b1 || bus_a.tally !== 32'h0001_0000 || bus_a.ballot_armed !== 1'b0 ||
        bus_a.led_enable !== 1'b1) begin
      $display("FAIL vote_cand2: got ack=%b tally=%h arm=%b led=%b, want 1 00010000 0 1",
               bus_a.vote_ack, bus_a.tally, bus_a.ballot_armed, bus_a.led_enable);
    end else pass_cnt++;
    step();
    total_cnt++;
    if (bus_a.vote_ack !== 1'b0) begin
      $display("FAIL ack_width: got ack=%b, want 0", bus_a.vote_ack);
    end else pass_cnt++;
    // Extra next_voter pulses while armed must not matter.
    pulse_next_a();
    pulse_next_a();
    pulse_vote_a(4'b0010);
    cast_a(1, 2);
    total_cnt++;
    if (bus_a.tally !== 32'h0001_0300) begin
      $display("FAIL vote_cand1x3: got tally=%h, want 00010300", bus_a.tally);
    end else pass_cnt++;
    $display("test_vote done");
  endtask

  task automatic test_err_timeout();
    pulse_next_a();
    pulse_vote_a(4'b0011);
    total_cnt++;
    if (bus_a.vote_err !== 1'b1 || bus_a.vote_ack !== 1'b0 || bus_a.ballot_armed !== 1'b1 ||
        bus_a.tally !== 32'h0001_0300) begin
      $display("FAIL vote_err: got err=%b ack=%b arm=%b tally=%h, want 1 0 1 00010300",
               bus_a.vote_err, bus_a.vote_ack, bus_a.ballot_armed, bus_a.tally);
    end else pass_cnt++;
    for (int t = 1; t <= 60; t++) begin
      bus_a.tick = 1'b1; step(); bus_a.tick = 1'b0;
      if (t == 1) begin
        total_cnt++;
        if (bus_a.vote_err !== 1'b0) begin
          $display("FAIL err_width: got err=%b, want 0", bus_a.vote_err);
        end else pass_cnt++;
      end
      if (t == 59) begin
        total_cnt++;
        if (bus_a.timeout !== 1'b0 || bus_a.ballot_armed !== 1'b1) begin
          $display("FAIL tick59: got to=%b arm=%b, want 0 1", bus_a.timeout, bus_a.ballot_armed);
        end else pass_cnt++;
      end
      step();
    end
    // One step already elapsed after tick 60; re-check via a fresh pulse sequence.
    total_cnt++;
    if (bus_a.timeout !== 1'b0 || bus_a.ballot_armed !== 1'b0 || bus_a.led_enable !== 1'b1) begin
      $display("FAIL after_timeout: got to=%b arm=%b led=%b, want 0 0 1",
               bus_a.timeout, bus_a.ballot_armed, bus_a.led_enable);
    end else pass_cnt++;
    // Second ballot: observe the timeout pulse itself on the 60th tick.
    pulse_next_a();
    for (int t = 1; t <= 60; t++) begin
      bus_a.tick = 1'b1; step(); bus_a.tick = 1'b0;
    end
    total_cnt++;
    if (bus_a.timeout !== 1'b1 || bus_a.ballot_armed !== 1'b0 || bus_a.led_enable !== 1'b1) begin
      $display("FAIL timeout_pulse: got to=%b arm=%b led=%b, want 1 0 1",
               bus_a.timeout, bus_a.ballot_armed, bus_a.led_enable);
    end else pass_cnt++;
    $display("test_err_timeout done");
  endtask

  task automatic test_close_winner();
    do_reset();
    pulse_open_a();
    cast_a(0, 5);
    cast_a(1, 7);
    cast_a(2, 7);
    cast_a(3, 2);
    total_cnt++;
    if (bus_a.tally !== 32'h0207_0705) begin
      $display("FAIL tally_mix: got tally=%h, want 02070705", bus_a.tally);
    end else pass_cnt++;
    bus_a.close_req = 1'b1; step(); bus_a.close_req = 1'b0;
    total_cnt++;
    if (bus_a.led_enable !== 1'b0 || bus_a.result_valid !== 1'b0) begin
      $display("FAIL closed_state: got led=%b rv=%b, want 0 0", bus_a.led_enable, bus_a.result_valid);
    end else pass_cnt++;
    pulse_open_a();
    step();
    step();
    step();
    total_cnt++;
    if (bus_a.result_valid !== 1'b0 || bus_a.led_enable !== 1'b0) begin
      $display("FAIL rv_early: got rv=%b led=%b at close+4, want 0 0", bus_a.result_valid, bus_a.led_enable);
    end else pass_cnt++;
    step();
    total_cnt++;
    if (bus_a.result_valid !== 1'b1 || bus_a.winner !== 3'd1 || bus_a.tie !== 1'b1) begin
      $display("FAIL winner_tie: got rv=%b win=%0d tie=%b at close+5, want 1 1 1",
               bus_a.result_valid, bus_a.winner, bus_a.tie);
    end else pass_cnt++;
    $display("test_close_winner done");
  endtask

  task automatic test_saturation();
    int acks;
    acks = 0;
    bus_b.open_req = 1'b1; step(); bus_b.open_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus_b.next_voter = 1'b1; step(); bus_b.next_voter = 1'b0;
      bus_b.vote_req = 4'b0001; step(); bus_b.vote_req = 4'b0000;
      if (bus_b.vote_ack === 1'b1) acks++;
    end
    total_cnt++;
    if (bus_b.tally[1:0] !== 2'd3 || acks != 5) begin
      $display("FAIL saturate: got tally0=%0d acks=%0d, want 3 5", bus_b.tally[1:0], acks);
    end else pass_cnt++;
    $display("test_saturation done");
  endtask

  task automatic test_close_vote_same();
    do_reset();
    pulse_open_a();
    pulse_next_a();
    bus_a.close_req = 1'b1;
    bus_a.vote_req  = 4'b0001;
    step();
    bus_a.close_req = 1'b0;
    bus_a.vote_req  = 4'b0000;
    total_cnt++;
    if (bus_a.led_enable !== 1'b0 || bus_a.ballot_armed !== 1'b0 || bus_a.vote_ack !== 1'b0 ||
        bus_a.tally !== 32'h0) begin
      $display("FAIL close_drops_vote: got led=%b arm=%b ack=%b tally=%h, want 0 0 0 0",
               bus_a.led_enable, bus_a.ballot_armed, bus_a.vote_ack, bus_a.tally);
    end else pass_cnt++;
    for (int k = 0; k < 5; k++) step();
    total_cnt++;
    if (bus_a.result_valid !== 1'b1 || bus_a.winner !== 3'd0 || bus_a.tie !== 1'b1) begin
      $display("FAIL zero_field: got rv=%b win=%0d tie=%b, want 1 0 1",
               bus_a.result_valid, bus_a.winner, bus_a.tie);
    end else pass_cnt++;
    do_reset();
    total_cnt++;
    if (bus_a.result_valid !== 1'b0 || bus_a.led_enable !== 1'b0 || bus_a.tally !== 32'h0 ||
        bus_a.tie !== 1'b0) begin
      $display("FAIL reset_closed: got rv=%b led=%b tally=%h tie=%b, want 0 0 0 0",
               bus_a.result_valid, bus_a.led_enable, bus_a.tally, bus_a.tie);
    end else pass_cnt++;
    pulse_open_a();
    total_cnt++;
    if (bus_a.led_enable !== 1'b1) begin
      $display("FAIL reopen: got led=%b, want 1", bus_a.led_enable);
    end else pass_cnt++;
    $display("test_close_vote_same done");
  endtask

  initial begin
    bus_a.tick = 1'b0; bus_a.open_req = 1'b0; bus_a.close_req = 1'b0;
    bus_a.next_voter = 1'b0; bus_a.vote_req = 4'b0;
    bus_b.tick = 1'b0; bus_b.open_req = 1'b0; bus_b.close_req = 1'b0;
    bus_b.next_voter = 1'b0; bus_b.vote_req = 4'b0;
    test_reset();
    test_open();
    test_vote();
    test_err_timeout();
    test_close_winner();
    test_saturation();
    test_close_vote_same();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vote_session_ctrl.md
Name: vote_session_ctrl

Overview:
- Central voting-session sequencer for the Nexys A7 voting machine. Runs on the system clock.
- Owns the session state: idle, polls open, one ballot armed per voter, polls closed.
- Drives the `enable` input of the LED driver and maintains saturating per-candidate tallies.
- After close, it scans the tallies sequentially to produce a winner and tie flag for the display logic.

Parameters:
- N_CAND, 4, number of candidates (2..8).
- CNT_W, 8, tally width per candidate in bits.
- TIMEOUT_TICKS, 60, tick pulses an armed ballot waits before auto-disarm (30 s at 2 Hz).

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high.
- tick  in  1  one-clk pulse at 2 Hz, clk-domain.
- open_req  in  1  debounced one-clk pulse: officer opens polls.
- close_req  in  1  debounced one-clk pulse: officer closes polls.
- next_voter  in  1  debounced one-clk pulse: officer arms one ballot.
- vote_req  in  N_CAND  debounced one-clk pulses, one per candidate button.
- led_enable  out  1  to the LED driver `enable`; high while polls are open.
- ballot_armed  out  1  high while a ballot is armed.
- vote_ack  out  1  one-clk pulse when a vote is counted.
- vote_err  out  1  one-clk pulse when an armed ballot receives an invalid vote_req.
- timeout  out  1  one-clk pulse when an armed ballot expires.
- tally  out  N_CAND*CNT_W  packed counts; candidate i occupies bits [i*CNT_W +: CNT_W].
- result_valid  out  1  winner/tie are valid.
- winner  out  3  index of the top candidate.
- tie  out  1  another candidate equals the top count.

Behaviour:
- Clock and reset: single clock; reset is synchronous, active-high.
- Reset values: state=IDLE, all outputs 0, tallies 0, timeout counter 0.
- Reset mid-session: tallies are cleared. Reset is the only way to clear tallies or leave CLOSED.
- FSM states: IDLE, OPEN, ARMED, CLOSED.
  - IDLE: open_req -> OPEN. All other inputs ignored.
  - OPEN: led_enable=1. close_req -> CLOSED. Otherwise next_voter -> ARMED and clears the timeout counter. vote_req ignored (no count, no vote_err).
  - ARMED: led_enable=1, ballot_armed=1.
    - vote_req exactly one-hot: tally[i] increments, vote_ack pulses the next cycle, -> OPEN.
    - vote_req non-zero but not one-hot: vote_err pulses, no count, stays ARMED.
    - Each tick increments the timeout counter. On reaching TIMEOUT_TICKS: timeout pulses, -> OPEN.
    - next_voter in ARMED is ignored.
  - CLOSED: led_enable=0, ballot_armed=0. Starts the winner scan on entry. All inputs ignored.
- Priority within one clk in ARMED: close_req > valid vote > timeout. A vote arriving together with close_req is dropped.
- Tally arithmetic: saturating at 2^CNT_W-1. A saturated vote still pulses vote_ack but does not change the count.
- Winner scan:
  - Runs one candidate per clk, indices 0..N_CAND-1.
  - result_valid rises N_CAND+1 clks after entering CLOSED and stays high until reset.
  - Strict greater-than compare, so the lowest index wins ties.
  - tie=1 if any later candidate equals the running max.
  - tie is recomputed when a new max is found.
- Outputs are registered; vote_ack, vote_err and timeout are each exactly one clk wide.

Optional Feature:
- Macro: VOTE_AUDIT_EN.
- Defined: adds outputs total_votes (CNT_W+3 bits, non-saturating count of every vote_ack) and reject_cnt (CNT_W bits, saturating count of vote_err plus timeout). Both reset to 0.
- Not defined: those ports and registers are absent. Behaviour is otherwise identical.

Decomposition:
- Package vote_pkg holds:
  - State encoding constants (IDLE=2'd0, OPEN=2'd1, ARMED=2'd2, CLOSED=2'd3).
  - Default N_CAND, CNT_W and TIMEOUT_TICKS.
  - A one-hot-check function.
- Sub-module max_scan: sequential argmax over the packed tally. Ports: clk, reset, start, tally -> done, winner, tie.

Test Plan:
- Reset, then open_req: next clk state=OPEN, led_enable=1. vote_req=4'b0010 in OPEN -> no ack, tally unchanged.
- open, next_voter, vote_req=4'b0100 -> vote_ack one clk later, tally[2]=1, back to OPEN. Repeat 3 voters on cand 1 -> tally[1]=3.
- ARMED with vote_req=4'b0011 -> vote_err pulse, no count, still ARMED. Then 60 tick pulses -> timeout pulse, OPEN.
- Votes {0:5, 1:7, 2:7, 3:2}, then close_req -> led_enable=0. After 5 clks result_valid=1, winner=1, tie=1.
- CNT_W=2 build, 5 votes for cand 0 -> tally[0]=3, 5 vote_acks.
- close_req and valid vote in the same ARMED clk -> CLOSED, vote dropped. Reset in CLOSED -> IDLE, tallies 0, result_valid=0.
